// File: rtl/peridot_pfc_pkg.sv
// Shared definitions for the PFC conduit responder.
// Holds command-word field positions, register offsets, pin and function
// codes, register reset values, and helpers that build the masks used to
// tie off unimplemented pins.
package peridot_pfc_pkg;

  // Command word layout: {wr, bank[1:0], reg[1:0], wdata[31:0]}
  localparam int CMD_W       = 37;
  localparam int CMD_WR      = 36;
  localparam int CMD_ADDR_HI = 35;
  localparam int CMD_ADDR_LO = 32;
  localparam int CMD_BANK_HI = 35;
  localparam int CMD_BANK_LO = 34;
  localparam int CMD_REG_HI  = 33;
  localparam int CMD_REG_LO  = 32;
  localparam int DATA_W      = 32;

  // Register offsets within a bank
  localparam logic [1:0] REG_DIN     = 2'd0;
  localparam logic [1:0] REG_DOUT    = 2'd1;
  localparam logic [1:0] REG_PINFUNC = 2'd2;
  localparam logic [1:0] REG_FUNCPIN = 2'd3;

  // Pin output codes (pinfunc nibbles)
  localparam logic [3:0] PFC_HIZ       = 4'h0;
  localparam logic [3:0] PFC_GPIO      = 4'h1;
  localparam logic [3:0] PFC_FUNC_BASE = 4'h8;

  // Function input codes (funcpin nibbles)
  localparam logic [3:0] PFC_CONST0 = 4'h8;
  localparam logic [3:0] PFC_CONST1 = 4'h9;

  // Reset values
  localparam logic [7:0]  DOUT_RST    = 8'h00;
  localparam logic [31:0] PINFUNC_RST = 32'h0000_0000;
  localparam logic [31:0] FUNCPIN_RST = 32'h8888_8888;

  // One bit set per implemented pin.
  function automatic logic [7:0] pin_mask(int count);
    logic [7:0] m;
    m = '0;
    for (int n = 0; n < 8; n++) begin
      if (n < count) m[n] = 1'b1;
    end
    return m;
  endfunction

  // One nibble set per implemented pin.
  function automatic logic [31:0] nib_mask(int count);
    logic [31:0] m;
    m = '0;
    for (int n = 0; n < 8; n++) begin
      if (n < count) m[4*n +: 4] = 4'hF;
    end
    return m;
  endfunction

endpackage

// File: rtl/peridot_pfc_pinmux.sv
// Per-pin output selector with its output register.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   code[3:0]           pinfunc nibble for this pin
//   dout                GPIO output level for this pin
//   func_out/func_oe    peripheral function outputs and enables 0..7
//   pin_out/pin_oe      registered pin level and enable
// ENABLE=0 marks an unimplemented pin whose outputs are held at 0.
module peridot_pfc_pinmux
  import peridot_pfc_pkg::*;
#(
  parameter bit ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] code,
  input  logic       dout,
  input  logic [7:0] func_out,
  input  logic [7:0] func_oe,
  output logic       pin_out,
  output logic       pin_oe
);

  logic out_d;
  logic oe_d;

  // Codes 0x0 and 0x2..0x7 are hi-Z; 0x1 is GPIO; 0x8..0xF select function c-8.
  always_comb begin
    out_d = 1'b0;
    oe_d  = 1'b0;
    if (code[3]) begin
      oe_d  = func_oe[code[2:0]];
      out_d = func_out[code[2:0]];
    end else if (code == PFC_GPIO) begin
      oe_d  = 1'b1;
      out_d = dout;
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk) begin
    if (!rst_n || !ENABLE) begin
      pin_out <= 1'b0;
      pin_oe  <= 1'b0;
    end else begin
      pin_out <= out_d;
      pin_oe  <= oe_d;
    end
  end

endmodule

// File: rtl/peridot_pfc_bank.sv
// PFC conduit responder for one 8-pin bank.
// Decodes the 37-bit command word, holds dout/pinfunc/funcpin, synchronises
// pin inputs, drives registered pin outputs/enables and routes pins to
// peripheral function inputs.
// Ports:
//   csi_clk, rsi_reset_n   clock and synchronous active-low reset
//   coe_pfc_cmd[36:0]      {wr, addr[3:0], wdata[31:0]}
//   coe_pfc_resp[31:0]     read data, 0 when this bank is not addressed
//   coe_pin_in[7:0]        asynchronous pin levels
//   coe_pin_out/oe[7:0]    registered pin levels and enables
//   func_out/func_oe[7:0]  peripheral function outputs and enables
//   func_in[7:0]           values routed to peripheral function inputs
module peridot_pfc_bank
  import peridot_pfc_pkg::*;
#(
  parameter int BANK_INDEX = 0,
  parameter int PIN_COUNT  = 8
) (
  input  logic              csi_clk,
  input  logic              rsi_reset_n,
  input  logic [CMD_W-1:0]  coe_pfc_cmd,
  output logic [DATA_W-1:0] coe_pfc_resp,
  input  logic [7:0]        coe_pin_in,
  output logic [7:0]        coe_pin_out,
  output logic [7:0]        coe_pin_oe,
  input  logic [7:0]        func_out,
  input  logic [7:0]        func_oe,
  output logic [7:0]        func_in
);

  localparam logic [7:0]  PIN_MASK = pin_mask(PIN_COUNT);
  localparam logic [31:0] NIB_MASK = nib_mask(PIN_COUNT);

  logic              wr;
  logic              sel;
  logic [1:0]        reg_sel;
  logic [DATA_W-1:0] wdata;
  logic [7:0]        wmask;

  logic [7:0]        dout;
  logic [31:0]       pinfunc;
  logic [31:0]       funcpin;
  logic [7:0]        din_p0;
  logic [7:0]        din_p1;
  logic [3:0]        fcode;

  assign wr      = coe_pfc_cmd[CMD_WR];
  assign sel     = (coe_pfc_cmd[CMD_BANK_HI:CMD_BANK_LO] == 2'(BANK_INDEX));
  assign reg_sel = coe_pfc_cmd[CMD_REG_HI:CMD_REG_LO];
  assign wdata   = coe_pfc_cmd[DATA_W-1:0];
  assign wmask   = wdata[15:8];

  // ---- register write stage ----
  // Unimplemented pins stay at their reset values through the masks.
  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      dout    <= DOUT_RST;
      pinfunc <= PINFUNC_RST;
      funcpin <= FUNCPIN_RST;
    end else if (wr && sel) begin
      case (reg_sel)
        REG_DOUT:    dout    <= ((dout & ~wmask) | (wdata[7:0] & wmask)) & PIN_MASK;
        REG_PINFUNC: pinfunc <= wdata & NIB_MASK;
        REG_FUNCPIN: funcpin <= wdata;
        default:     ;
      endcase
    end
  end

  // ---- two-flop input synchroniser ----
  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      din_p0 <= '0;
      din_p1 <= '0;
    end else begin
      din_p0 <= coe_pin_in & PIN_MASK;
      din_p1 <= din_p0;
    end
  end

  // Read mux; zero when not addressed so the bank responses can be ORed.
  always_comb begin
    coe_pfc_resp = '0;
    if (sel) begin
      case (reg_sel)
        REG_DIN:     coe_pfc_resp = {24'b0, din_p1};
        REG_DOUT:    coe_pfc_resp = {24'b0, dout};
        REG_PINFUNC: coe_pfc_resp = pinfunc;
        REG_FUNCPIN: coe_pfc_resp = funcpin;
        default:     coe_pfc_resp = '0;
      endcase
    end
  end

  // Function input mux: pin select when c[3]=0, else constant (1 only for 0x9).
  // Unimplemented pins read as 0 because din_p1 is masked.
  always_comb begin
    func_in = '0;
    fcode   = '0;
    for (int k = 0; k < 8; k++) begin
      fcode = funcpin[4*k +: 4];
      if (!fcode[3]) func_in[k] = din_p1[fcode[2:0]];
      else           func_in[k] = (fcode == PFC_CONST1);
    end
  end

  for (genvar n = 0; n < 8; n++) begin : g_pin
    peridot_pfc_pinmux #(
      .ENABLE (n < PIN_COUNT)
    ) u_pinmux (
      .clk      (csi_clk),
      .rst_n    (rsi_reset_n),
      .code     (pinfunc[4*n +: 4]),
      .dout     (dout[n]),
      .func_out (func_out),
      .func_oe  (func_oe),
      .pin_out  (coe_pin_out[n]),
      .pin_oe   (coe_pin_oe[n])
    );
  end

endmodule

// File: tb/tb_peridot_pfc_bank.sv
// Scoreboard bench for peridot_pfc_bank: bank A (index 1, 8 pins) and
// bank B (index 2, 6 pins) share the conduit and pin inputs.
module tb_peridot_pfc_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [36:0] cmd;
  logic [7:0]  pin_in, func_out, func_oe;
  logic [31:0] resp_a, resp_b;
  logic [7:0]  pin_out_a, pin_oe_a, func_in_a;
  logic [7:0]  pin_out_b, pin_oe_b, func_in_b;

  peridot_pfc_bank #(.BANK_INDEX(1), .PIN_COUNT(8)) dut_a (
    .csi_clk(clk), .rsi_reset_n(rst_n), .coe_pfc_cmd(cmd), .coe_pfc_resp(resp_a),
    .coe_pin_in(pin_in), .coe_pin_out(pin_out_a), .coe_pin_oe(pin_oe_a),
    .func_out(func_out), .func_oe(func_oe), .func_in(func_in_a)
  );

  peridot_pfc_bank #(.BANK_INDEX(2), .PIN_COUNT(6)) dut_b (
    .csi_clk(clk), .rsi_reset_n(rst_n), .coe_pfc_cmd(cmd), .coe_pfc_resp(resp_b),
    .coe_pin_in(pin_in), .coe_pin_out(pin_out_b), .coe_pin_oe(pin_oe_b),
    .func_out(func_out), .func_oe(func_oe), .func_in(func_in_b)
  );

  typedef enum int {
    S_RESP_A, S_RESP_B, S_OUT_A, S_OE_A, S_FIN_A, S_OUT_B, S_OE_B, S_FIN_B
  } sig_e;

  typedef struct {
    sig_e        sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [31:0] sample(sig_e s);
    case (s)
      S_RESP_A: return resp_a;
      S_RESP_B: return resp_b;
      S_OUT_A:  return {24'b0, pin_out_a};
      S_OE_A:   return {24'b0, pin_oe_a};
      S_FIN_A:  return {24'b0, func_in_a};
      S_OUT_B:  return {24'b0, pin_out_b};
      S_OE_B:   return {24'b0, pin_oe_b};
      default:  return {24'b0, func_in_b};
    endcase
  endfunction

  // Monitor: compares every pending expectation at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = sample(e.sig);
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(sig_e s, logic [31:0] v, string n);
    sb.push_back('{s, v, n});
  endtask

  task automatic rd(logic [3:0] a);
    cmd = {1'b0, a, 32'h0};
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] d);
    cmd = {1'b1, a, d};
    tick();
    cmd = '0;
  endtask

  task automatic rd_check(sig_e s, logic [3:0] a, logic [31:0] v, string n);
    rd(a);
    push(s, v, n);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    cmd      = '0;
    pin_in   = '0;
    func_out = '0;
    func_oe  = '0;
    tick();
    tick();

    // Reset state
    rd(4'h7);
    push(S_RESP_A, 32'h8888_8888, "rst_funcpin_a");
    push(S_OE_A, 32'h0, "rst_oe_a");
    push(S_OUT_A, 32'h0, "rst_out_a");
    push(S_FIN_A, 32'h0, "rst_fin_a");
    tick();
    rst_n = 1'b1;

    // Test 1: register reads, bank select
    rd_check(S_RESP_A, 4'h4, 32'h0, "t1_din");
    rd_check(S_RESP_A, 4'h5, 32'h0, "t1_dout");
    rd_check(S_RESP_A, 4'h6, 32'h0, "t1_pinfunc");
    rd(4'h7);
    push(S_RESP_A, 32'h8888_8888, "t1_funcpin");
    push(S_RESP_B, 32'h0, "t1_b_unsel");
    tick();
    rd_check(S_RESP_A, 4'h0, 32'h0, "t1_a_unsel_0");
    rd(4'hB);
    push(S_RESP_B, 32'h8888_8888, "t1_b_funcpin");
    push(S_RESP_A, 32'h0, "t1_a_unsel_b");
    tick();

    // Test 2: GPIO with masked dout writes
    wr(4'h6, 32'h1111_1111);
    wr(4'h5, 32'h0000_FFA5);
    tick();
    push(S_OE_A, 32'hFF, "t2_oe");
    push(S_OUT_A, 32'hA5, "t2_out_a5");
    tick();
    rd_check(S_RESP_A, 4'h5, 32'hA5, "t2_rd_dout");
    cmd = {1'b1, 4'h5, 32'h0000_0F00};
    push(S_RESP_A, 32'hA5, "t2_rd_during_wr");
    tick();
    rd(4'h5);
    push(S_RESP_A, 32'hA0, "t2_rd_after_wr");
    push(S_OUT_A, 32'hA5, "t2_out_not_yet");
    tick();
    cmd = '0;
    push(S_OUT_A, 32'hA0, "t2_out_a0");
    tick();

    // Test 3: function outputs on pins 0 and 3
    func_oe  = 8'h09;
    func_out = 8'h08;
    wr(4'h6, 32'h0000_B008);
    tick();
    push(S_OE_A, 32'h09, "t3_oe");
    push(S_OUT_A, 32'h08, "t3_out");
    tick();
    func_out = 8'h00;
    push(S_OUT_A, 32'h08, "t3_func_chg_not_yet");
    tick();
    push(S_OUT_A, 32'h00, "t3_func_chg");
    push(S_OE_A, 32'h09, "t3_oe_hold");
    tick();

    // Test 4: function input routing and synchroniser latency
    wr(4'h7, 32'h0000_0925);
    push(S_FIN_A, 32'h04, "t4_fin_init");
    tick();
    pin_in = 8'h24;
    push(S_FIN_A, 32'h04, "t4_fin_pre");
    tick();
    push(S_FIN_A, 32'h04, "t4_fin_1clk");
    tick();
    push(S_FIN_A, 32'h07, "t4_fin_2clk");
    tick();
    rd_check(S_RESP_B, 4'h8, 32'h24, "t4_b_din");
    pin_in = 8'hE4;
    tick();
    tick();
    rd_check(S_RESP_A, 4'h4, 32'hE4, "t4_a_din");
    rd_check(S_RESP_B, 4'h8, 32'h24, "t4_b_din_masked");
    push(S_FIN_A, 32'h07, "t4_fin_e4");
    tick();
    wr(4'hB, 32'h0000_0007);
    push(S_FIN_B, 32'h00, "t4_b_unimpl_pin");
    tick();

    // Test 5: 6-pin bank tie-offs
    wr(4'h9, 32'h0000_FFFF);
    wr(4'hA, 32'h1111_1111);
    rd_check(S_RESP_B, 4'h9, 32'h3F, "t5_dout");
    rd(4'hA);
    push(S_RESP_B, 32'h0011_1111, "t5_pinfunc");
    push(S_OE_B, 32'h3F, "t5_oe");
    push(S_OUT_B, 32'h3F, "t5_out");
    tick();

    // Test 6: reset overrides concurrent write
    cmd   = {1'b1, 4'h6, 32'hFFFF_FFFF};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rd(4'h6);
    push(S_RESP_A, 32'h0, "t6_pinfunc");
    push(S_OE_A, 32'h0, "t6_oe");
    push(S_OE_B, 32'h0, "t6_oe_b");
    tick();
    rd(4'h7);
    push(S_RESP_A, 32'h8888_8888, "t6_funcpin");
    push(S_OE_A, 32'h0, "t6_oe_hold");
    tick();
    rd_check(S_RESP_A, 4'h5, 32'h0, "t6_dout");

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
      $fatal(1, "scoreboard not drained");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/peridot_pfc_bank.md
Name: peridot_pfc_bank

Overview:
- Responder end of the PFC conduit: decodes the 37-bit command word from the Avalon-side PFC interface and returns its 32-bit read response.
- One instance serves one 8-pin bank. It holds the dout, pinfunc and funcpin registers, synchronises pin inputs, and drives registered pin outputs and enables.
- The top level ORs four instances' responses onto coe_pfc_resp.

Parameters:
- BANK_INDEX, 0: bank number 0..3; the bank responds when cmd[35:34]==BANK_INDEX.
- PIN_COUNT, 8: number of implemented pins, 1..8. Pins at or above PIN_COUNT are unimplemented.

Ports:
- csi_clk  in  1  single clock; the integrator connects coe_pfc_clk to it.
- rsi_reset_n  in  1  synchronous, active-low reset; the integrator connects the inverse of coe_pfc_reset to it.
- coe_pfc_cmd  in  37  bit36 write strobe, bits35:32 word address, bits31:0 write data.
- coe_pfc_resp  out  32  read data for the addressed register; 0 when the bank is not addressed.
- coe_pin_in  in  8  raw pin levels (asynchronous).
- coe_pin_out  out  8  registered pin output levels.
- coe_pin_oe  out  8  registered pin output enables.
- func_out  in  8  peripheral function outputs 0..7.
- func_oe  in  8  peripheral function output enables 0..7.
- func_in  out  8  values routed to peripheral function inputs 0..7.

Behaviour:
- Reset (rsi_reset_n=0 at a clock edge):
  - dout=0, pinfunc=0x00000000, funcpin=0x88888888.
  - Synchroniser flops=0; coe_pin_out=0, coe_pin_oe=0.
  - func_in=0 and coe_pfc_resp=0 follow combinationally from the reset register values.
- Address select: sel = cmd[35:34]==BANK_INDEX; reg = cmd[33:32].
- Write:
  - Takes effect on the clock edge where cmd[36]=1 and sel=1. There is no wait state and no back-pressure.
  - The strobe is honoured every cycle it is high; consecutive writes are all applied.
- reg0 (din, read-only): writes are ignored. Read returns {24'b0, din_sync}.
- reg1 (mask/dout):
  - Write: for each n, dout[n] <= wdata[8+n] ? wdata[n] : dout[n].
  - Read returns {24'b0, dout}; the mask bits read as 0.
- reg2 (pinfunc): write loads pinfunc <= wdata. Read returns pinfunc.
- reg3 (funcpin): write loads funcpin <= wdata. Read returns funcpin.
- Unimplemented pins (n>=PIN_COUNT):
  - Their register bits and nibbles are tied to their reset values and read back as such.
  - Their coe_pin_oe and coe_pin_out are held at 0.
- coe_pfc_resp is combinational from cmd address and state. It is 0 when sel=0, so the top-level OR needs no arbitration. The Avalon side registers it.
- din_sync: two-flop synchroniser per pin. Latency from a coe_pin_in edge to din_sync is 2 clocks.
- Pin mux, per pin n, on code c = pinfunc[4n+3:4n]:
  - c=0x0..0x7: hi-Z (oe=0, out=0).
  - c=0x1 is the exception: GPIO, oe=1, out=dout[n].
  - c=0x8..0xF: function c-8, oe=func_oe[c-8], out=func_out[c-8].
  - coe_pin_out and coe_pin_oe are registered: one clock from a register write or func change.
- Function mux, per function k, on code c = funcpin[4k+3:4k] (combinational):
  - c[3]=0: func_in[k]=din_sync[c[2:0]]. Selecting an unimplemented pin yields 0.
  - c=0x9: constant 1.
  - Any other code with c[3]=1: constant 0.
- Simultaneous events:
  - A write to dout in cycle t is visible on coe_pin_out at t+2: register at t+1, output register at t+2.
  - A read of reg1 in the cycle after the write returns the new value.
  - A write and a read cannot occur in the same cycle on the conduit. If cmd[36]=1, resp still reflects the pre-write state.
- Reset asserted mid-operation overrides any concurrent write.

Decomposition:
- Package peridot_pfc_pkg holds:
  - Register offsets REG_DIN=0, REG_DOUT=1, REG_PINFUNC=2, REG_FUNCPIN=3.
  - Pin codes PFC_HIZ=0x0, PFC_GPIO=0x1, PFC_FUNC_BASE=0x8.
  - Function-input codes PFC_CONST0=0x8, PFC_CONST1=0x9.
  - Reset constants and the cmd field positions (WR=36, ADDR 35:32).
- Sub-module peridot_pfc_pinmux holds the per-pin output selector plus its output register; it is instantiated 8 times.

Test Plan:
1. Reset then read reg0..reg3 with BANK_INDEX=1 at address 0x4..0x7 -> resp 0, 0, 0x00000000, 0x88888888. Read address 0x0 -> resp 0 (bank not selected).
2. pinfunc=0x11111111; write reg1 with 0x0000FFA5; then write reg1 with 0x00000F00 -> coe_pin_oe=0xFF, coe_pin_out=0xA5 then 0xA0. The second write updates only bits 3:0 (to 0); bits 7:4 are held at 0xA.
3. pinfunc: pin0 code 0x8, pin3 code 0xB; func_oe=0x09, func_out=0x08 -> coe_pin_oe[0]=1, coe_pin_oe[3]=1, coe_pin_out[0]=0, coe_pin_out[3]=1. Every other pin has oe=0 and out=0.
4. funcpin=0x00000925 -> func_in[0]=din_sync[5], func_in[1]=din_sync[2], func_in[2]=1, func_in[7:3]=0. A coe_pin_in[5] edge appears on func_in[0] after exactly 2 clocks.
5. PIN_COUNT=6: write reg1 with 0x0000FFFF and pinfunc=0x11111111 -> reg1 reads 0x3F, pinfunc reads 0x00111111, coe_pin_oe=0x3F.
6. Assert rsi_reset_n=0 in the same cycle as a write of 0xFFFFFFFF to pinfunc -> pinfunc reads 0 afterwards and coe_pin_oe=0.
